alu_pipe_gen: RTL and testbench

Parametrised, handshaked successor to the generated pipelined ALUs. It is a two-stage valid/ready pipeline with a configurable datapath width and the same 12-operation opcode map. Every operation, including SGT and SNE, produces a defined result, and all flags are computed from the current result. It adds an iterative multi-cycle divider that stalls the pipeline, plus full output backpressure. It sits between the operand-issue logic and the writeback stage of the generated datapaths.

---
 rtl/alu_pipe_gen_if.sv | 19 +
 rtl/alu_pipe_gen.sv | 124 ++++++++++++
 tb/tb_alu_pipe_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_gen_if.sv
// alu_pipe_gen_if: operand-issue handshake, result handshake and flags for alu_pipe_gen.
interface alu_pipe_gen_if #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [3:0] opcode;
  logic [WIDTH-1:0] input1, input2, result;
  logic [SHW-1:0] shiftValue;
  logic carryFlag, zeroFlag, overFlowFlag, signFlag, divByZero;
  modport master (
    output in_valid, opcode, input1, input2, shiftValue, out_ready,
    input in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag, signFlag, divByZero
  );
  modport slave (
    input in_valid, opcode, input1, input2, shiftValue, out_ready,
    output in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag, signFlag, divByZero
  );
endinterface

// File: rtl/alu_pipe_gen.sv
// alu_pipe_gen: two-stage valid/ready ALU; define ALU_GEN_DIV_EN to build the iterative
// restoring divider, otherwise DIV completes at once and raises divByZero as "unsupported".
module alu_pipe_gen #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  alu_pipe_gen_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_NAND = 4'd3,
                         OP_SRL = 4'd4, OP_DIV = 4'd5, OP_SLL = 4'd6, OP_XNOR = 4'd7,
                         OP_ROR = 4'd8, OP_SGT = 4'd9, OP_MAX = 4'd10, OP_SNE = 4'd11;
  logic s1_valid, s1_done, s1_advance, accept;
  logic [3:0] s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, res;
  logic [SHW-1:0] s1_sh;
  logic c, v, d;
  logic [WIDTH:0] sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic s2_valid;
  logic [WIDTH-1:0] s2_res;
  logic [4:0] s2_flags;
  assign accept = bus.in_valid && bus.in_ready;
  assign s1_advance = s1_valid && s1_done && (!s2_valid || bus.out_ready);
  assign bus.in_ready = !s1_valid || s1_advance;
  assign bus.out_valid = s2_valid;
  assign bus.result = s2_res;
  assign {bus.carryFlag, bus.zeroFlag, bus.overFlowFlag, bus.signFlag, bus.divByZero} = s2_flags;
`ifdef ALU_GEN_DIV_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo;
  logic [WIDTH:0] trial;
  logic div_busy, fits;
  // quo starts as the dividend and shifts quotient bits in from the right
  assign trial = {rem, quo[WIDTH-1]};
  assign fits = trial >= {1'b0, s1_b};
  assign div_busy = s1_valid && s1_op == OP_DIV && s1_b != '0 && cnt != CW'(WIDTH);
  assign s1_done = !div_busy;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
    end else if (accept) begin
      cnt <= '0;
      rem <= '0;
      quo <= bus.input1;
    end else if (div_busy) begin
      cnt <= cnt + 1'b1;
      rem <= fits ? WIDTH'(trial - {1'b0, s1_b}) : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], fits};
    end
`else
  assign s1_done = 1'b1;
`endif
  always_comb begin
    sum = {1'b0, s1_a} + {1'b0, s1_b};
    diff = {1'b0, s1_a} - {1'b0, s1_b};
    prod = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
    res = '0;
    c = 1'b0;
    v = 1'b0;
    d = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = s1_a[WIDTH-1] == s1_b[WIDTH-1] && res[WIDTH-1] != s1_a[WIDTH-1];
      end
      OP_SUB: begin
        res = diff[WIDTH-1:0];
        c = diff[WIDTH];
        v = s1_a[WIDTH-1] != s1_b[WIDTH-1] && res[WIDTH-1] != s1_a[WIDTH-1];
      end
      OP_MUL: begin
        res = prod[WIDTH-1:0];
        c = |prod[2*WIDTH-1:WIDTH];
      end
      OP_NAND: res = ~(s1_a & s1_b);
      OP_SRL: res = s1_a >> s1_sh;
`ifdef ALU_GEN_DIV_EN
      OP_DIV: begin
        res = s1_b == '0 ? '1 : quo;
        d = s1_b == '0;
      end
`else
      OP_DIV: d = 1'b1;
`endif
      OP_SLL: res = s1_a << s1_sh;
      OP_XNOR: res = ~(s1_a ^ s1_b);
      OP_ROR: res = WIDTH'({s1_a, s1_a} >> s1_sh);
      OP_SGT: res = WIDTH'($signed(s1_a) > $signed(s1_b));
      OP_MAX: res = s1_a > s1_b ? s1_a : s1_b;
      OP_SNE: res = WIDTH'(s1_a != s1_b);
      default: ;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op <= '0;
      s1_a <= '0;
      s1_b <= '0;
      s1_sh <= '0;
      s2_valid <= 1'b0;
      s2_res <= '0;
      s2_flags <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op <= bus.opcode;
        s1_a <= bus.input1;
        s1_b <= bus.input2;
        s1_sh <= bus.shiftValue;
      end else if (s1_advance) s1_valid <= 1'b0;
      if (s1_advance) begin
        s2_valid <= 1'b1;
        s2_res <= res;
        s2_flags <= {c, res == '0, v, res[WIDTH-1], d};
      end else if (bus.out_ready) s2_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_pipe_gen.sv
// tb_alu_pipe_gen: directed and randomized checks of alu_pipe_gen against an arithmetic reference model.
module tb_alu_pipe_gen;
  localparam int W = 32;
`ifdef ALU_GEN_DIV_EN
  localparam int DIV_LAT = W + 2, DIV_LOW = W;
`else
  localparam int DIV_LAT = 2, DIV_LOW = 0;
`endif
  localparam longint SMAX = 64'sd2147483647, SMIN = -64'sd2147483648;
  typedef struct packed {
    logic [W-1:0] r;
    logic c, z, v, s, d;
  } res_t;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0, drained = 0;
  res_t q[$];
  res_t held;
  logic hold_prev = 1'b0;
  always #5 clk = ~clk;
  alu_pipe_gen_if #(.WIDTH(W)) bus ();
  alu_pipe_gen #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  function automatic res_t mk(input logic [W-1:0] r, input logic c, z, v, s, d);
    return {r, c, z, v, s, d};
  endfunction
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, b, input logic [4:0] sh);
    res_t m;
    longint sa, sb;
    logic [63:0] p;
    logic [W-1:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m = '0;
    case (op)
      0: begin m.r = a + b; m.c = 64'(a) + 64'(b) > 64'hFFFF_FFFF; m.v = sa + sb > SMAX || sa + sb < SMIN; end
      1: begin m.r = a - b; m.c = a < b; m.v = sa - sb > SMAX || sa - sb < SMIN; end
      2: begin p = 64'(a) * 64'(b); m.r = p[31:0]; m.c = p > 64'hFFFF_FFFF; end
      3: m.r = ~(a & b);
      4: m.r = a >> sh;
`ifdef ALU_GEN_DIV_EN
      5: begin m.r = b == 0 ? 32'hFFFF_FFFF : a / b; m.d = b == 0; end
`else
      5: m.d = 1'b1;
`endif
      6: m.r = a << sh;
      7: m.r = ~(a ^ b);
      8: begin t = a; for (int i = 0; i < sh; i++) t = {t[0], t[W-1:1]}; m.r = t; end
      9: m.r = {31'b0, sa > sb};
      10: m.r = a > b ? a : b;
      11: m.r = {31'b0, a != b};
      default: ;
    endcase
    m.z = m.r == 0;
    m.s = m.r[W-1];
    return m;
  endfunction
  function automatic res_t observe();
    return {bus.result, bus.carryFlag, bus.zeroFlag, bus.overFlowFlag, bus.signFlag, bus.divByZero};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic set_in(input logic iv, input logic [3:0] op, input logic [W-1:0] a, b, input logic [4:0] sh);
    bus.in_valid = iv;
    bus.opcode = op;
    bus.input1 = a;
    bus.input2 = b;
    bus.shiftValue = sh;
  endtask
  // one isolated op: latency in edges from acceptance, result/flags, and cycles with in_ready low
  task automatic single(input string tag, input logic [3:0] op, input logic [W-1:0] a, b, input logic [4:0] sh,
                        input res_t exp, input int lat, input int low);
    int edges, lows;
    set_in(1'b1, op, a, b, sh);
    bus.out_ready = 1'b1;
    #1;
    edges = 0;
    while (!bus.in_ready && edges < 100) begin @(posedge clk); #1; edges++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    edges = 1;
    lows = 0;
    while (!bus.out_valid && edges < 200) begin
      lows += int'(!bus.in_ready);
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, edges, lat);
    check({tag, " result"}, observe(), exp);
    check({tag, " stall"}, lows, low);
    @(posedge clk); #1;
  endtask
  task automatic step(input logic iv, input logic ordy, input logic [3:0] op, input logic [W-1:0] a, b,
                      input logic [4:0] sh, output logic acc);
    res_t cur;
    set_in(iv, op, a, b, sh);
    bus.out_ready = ordy;
    #2;
    cur = observe();
    acc = bus.in_valid && bus.in_ready;
    if (hold_prev) check("hold", {bus.out_valid, cur}, {1'b1, held});
    if (bus.out_valid && bus.out_ready) begin
      drained++;
      check("queue nonempty", q.size() != 0, 1'b1);
      if (q.size() != 0) check("stream", cur, q.pop_front());
    end
    if (acc) q.push_back(model(op, a, b, sh));
    hold_prev = bus.out_valid && !bus.out_ready;
    held = cur;
    @(posedge clk); #1;
  endtask
  initial begin
    logic acc;
    int k;
    logic [3:0] bb_op[4];
    logic [W-1:0] bb_a[4], bb_b[4];
    logic [4:0] bb_sh[4];
    res_t bb_exp[4];
    logic [3:0] bp_op[3];
    logic [W-1:0] bp_a[3], bp_b[3];
    logic [3:0] op;
    logic [W-1:0] a, b;
    set_in(1'b0, 4'd0, '0, '0, '0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset state", {bus.out_valid, bus.in_ready, observe()}, {2'b01, 37'b0});
    single("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, mk(32'd0, 1, 1, 0, 0, 0), 2, 0);
    single("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, mk(32'h8000_0000, 0, 0, 1, 1, 0), 2, 0);
    single("sub_borrow", 4'd1, 32'd3, 32'd5, 5'd0, mk(32'hFFFF_FFFE, 1, 0, 0, 1, 0), 2, 0);
    single("sgt_neg", 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd0, mk(32'd0, 0, 1, 0, 0, 0), 2, 0);
    single("sne_eq", 4'd11, 32'd7, 32'd7, 5'd0, mk(32'd0, 0, 1, 0, 0, 0), 2, 0);
    single("undef_op", 4'd13, 32'hDEAD_BEEF, 32'd9, 5'd3, mk(32'd0, 0, 1, 0, 0, 0), 2, 0);
`ifdef ALU_GEN_DIV_EN
    single("div", 4'd5, 32'd100, 32'd7, 5'd0, mk(32'd14, 0, 0, 0, 0, 0), DIV_LAT, DIV_LOW);
    single("div_zero", 4'd5, 32'd55, 32'd0, 5'd0, mk(32'hFFFF_FFFF, 0, 0, 0, 1, 1), 2, 0);
`else
    single("div", 4'd5, 32'd100, 32'd7, 5'd0, mk(32'd0, 0, 1, 0, 0, 1), DIV_LAT, DIV_LOW);
    single("div_zero", 4'd5, 32'd55, 32'd0, 5'd0, mk(32'd0, 0, 1, 0, 0, 1), 2, 0);
`endif
    bb_op = '{4'd0, 4'd7, 4'd8, 4'd10};
    bb_a = '{32'd5, 32'hF0F0_F0F0, 32'd1, 32'd3};
    bb_b = '{32'd6, 32'h0F0F_0F0F, 32'd0, 32'd9};
    bb_sh = '{5'd0, 5'd0, 5'd1, 5'd0};
    bb_exp[0] = mk(32'd11, 0, 0, 0, 0, 0);
    bb_exp[1] = mk(32'd0, 0, 1, 0, 0, 0);
    bb_exp[2] = mk(32'h8000_0000, 0, 0, 0, 1, 0);
    bb_exp[3] = mk(32'd9, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_in(1'b1, bb_op[i], bb_a[i], bb_b[i], bb_sh[i]);
      else bus.in_valid = 1'b0;
      #1;
      if (i < 4) check("b2b in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      if (i >= 1 && i <= 4) check("b2b out", {bus.out_valid, observe()}, {1'b1, bb_exp[i-1]});
    end
    bp_op = '{4'd0, 4'd1, 4'd2};
    bp_a = '{32'd1000, 32'd50, 32'h0001_0000};
    bp_b = '{32'd24, 32'd80, 32'h0001_0003};
    k = 0;
    drained = 0;
    for (int i = 0; i < 7; i++) begin
      step(k < 3, 1'b0, bp_op[k > 2 ? 2 : k], bp_a[k > 2 ? 2 : k], bp_b[k > 2 ? 2 : k], 5'd0, acc);
      if (acc) k++;
    end
    check("bp accepted", k, 2);
    check("bp in_ready", bus.in_ready, 1'b0);
    check("bp out_valid", bus.out_valid, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(k < 3, 1'b1, bp_op[k > 2 ? 2 : k], bp_a[k > 2 ? 2 : k], bp_b[k > 2 ? 2 : k], 5'd0, acc);
      if (acc) k++;
    end
    check("bp drained", drained, 3);
    check("bp queue empty", q.size(), 0);
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom_range(0, 4) == 0 ? a : $urandom;
      if ($urandom_range(0, 9) == 0) b = '0;
      if ($urandom_range(0, 4) == 0) a = $urandom_range(0, 255);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, op, a, b, 5'($urandom), acc);
    end
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 4'd0, '0, '0, '0, acc);
    check("random queue empty", q.size(), 0);
    hold_prev = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1'b1, 4'd5, 32'd100, 32'd7, 5'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort state", {bus.out_valid, bus.in_ready, observe()}, {2'b01, 37'b0});
    repeat (40) @(posedge clk);
    #1;
    check("abort quiet", bus.out_valid, 1'b0);
    single("post_abort_add", 4'd0, 32'd20, 32'd22, 5'd0, mk(32'd42, 0, 0, 0, 0, 0), 2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
